pc_sequencer: RTL and testbench

//   Program-counter register and next-PC sequencer for the instruction-fetch stage.

---
 rtl/pc_sequencer.sv | 93 +++++++++
 tb/tb_pc_sequencer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: holds the fetch address, picks the next PC
// from sequential/branch/jump sources, and handles stalls, back-pressure and redirects.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Stall,
   input  logic             BranchTaken,
   input  logic [31:0]      BranchTarget,
   input  logic             Jump,
   input  logic [31:0]      JumpTarget,
   input  logic             IMemReady,
   output logic [31:0]      PCResult,
   output logic [31:0]      PCAddResult,
   output logic             FetchValid,
   output logic             Flush,
   output logic             AlignErr,
   output logic [CNT_W-1:0] FetchCount
);

   typedef enum logic [1:0] {BOOT, RUN, HOLD, ERROR} state_t;

   state_t           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic             flush_q, flush_d;
   logic             align_err_q, align_err_d;
   logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;

   logic             redirect;
   logic [31:0]      target;

   assign redirect = Jump | BranchTaken;
   assign target   = Jump ? JumpTarget : BranchTarget;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      flush_d     = 1'b0;
      align_err_d = align_err_q;
      fetch_cnt_d = fetch_cnt_q;
      case (state_q)
         BOOT: state_d = RUN;
         RUN, HOLD: begin
            // A redirect wins over stall and back-pressure in both states.
            if (redirect) begin
               if (target[1:0] == 2'b00) begin
                  pc_d    = target;
                  flush_d = 1'b1;
                  state_d = RUN;
               end else begin
                  align_err_d = 1'b1;
                  state_d     = ERROR;
               end
            end else if (Stall) begin
               state_d = HOLD;
            end else if (state_q == HOLD) begin
               state_d = RUN;
            end else if (IMemReady) begin
               pc_d        = PCAddResult;
               fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
            end
         end
         ERROR: state_d = ERROR;
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= BOOT;
         pc_q        <= RESET_PC;
         flush_q     <= 1'b0;
         align_err_q <= 1'b0;
         fetch_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         flush_q     <= flush_d;
         align_err_q <= align_err_d;
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   assign PCResult    = pc_q;
   assign PCAddResult = pc_q + 32'd4;
   assign FetchValid  = (state_q == RUN);
   assign Flush       = flush_q;
   assign AlignErr    = align_err_q;
   assign FetchCount  = fetch_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer; each row gives the inputs of a
// cycle and the outputs expected during that same cycle (before its clock edge).
module tb_pc_sequencer;

   logic        Clk = 1'b0;
   logic        Reset, Stall, BranchTaken, Jump, IMemReady;
   logic [31:0] BranchTarget, JumpTarget;
   logic [31:0] PCResult, PCAddResult;
   logic        FetchValid, Flush, AlignErr;
   logic [15:0] FetchCount;

   pc_sequencer #(.RESET_PC(32'h0), .CNT_W(16)) dut (
      .Clk(Clk), .Reset(Reset), .Stall(Stall),
      .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
      .Jump(Jump), .JumpTarget(JumpTarget), .IMemReady(IMemReady),
      .PCResult(PCResult), .PCAddResult(PCAddResult), .FetchValid(FetchValid),
      .Flush(Flush), .AlignErr(AlignErr), .FetchCount(FetchCount)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic        rst, stall, br;
      logic [31:0] bt;
      logic        jmp;
      logic [31:0] jt;
      logic        rdy, chk;
      logic [31:0] pc;
      logic        fv, fl, ae;
      logic [15:0] cnt;
   } vec_t;

   vec_t tbl[$];
   int   nvec = 0;
   int   nerr = 0;

   task automatic add(input logic rst, stall, br, input logic [31:0] bt,
                      input logic jmp, input logic [31:0] jt, input logic rdy, chk,
                      input logic [31:0] pc, input logic fv, fl, ae, input logic [15:0] cnt);
      vec_t v;
      v = '{rst, stall, br, bt, jmp, jt, rdy, chk, pc, fv, fl, ae, cnt};
      tbl.push_back(v);
   endtask

   task automatic cmp(input string name, input int idx, input logic [31:0] act, exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic rst, stall, br, input logic [31:0] bt,
                        input logic jmp, input logic [31:0] jt, input logic rdy);
      Reset = rst; Stall = stall; BranchTaken = br; BranchTarget = bt;
      Jump = jmp; JumpTarget = jt; IMemReady = rdy;
   endtask

   task automatic check_all(input int idx, input logic [31:0] pc, input logic fv, fl, ae,
                            input logic [15:0] cnt);
      cmp("PCResult", idx, PCResult, pc);
      cmp("PCAddResult", idx, PCAddResult, pc + 32'd4);
      cmp("FetchValid", idx, {31'b0, FetchValid}, {31'b0, fv});
      cmp("Flush", idx, {31'b0, Flush}, {31'b0, fl});
      cmp("AlignErr", idx, {31'b0, AlignErr}, {31'b0, ae});
      cmp("FetchCount", idx, {16'b0, FetchCount}, {16'b0, cnt});
   endtask

   initial begin
      logic [31:0] m_pc;
      logic [15:0] m_cnt;
      logic        r;
      //   rst st br bt            jmp jt            rdy chk  pc            fv fl ae cnt
      add(1, 0, 0, 32'h0,        0, 32'h0,        1,  0,   32'h0,        0, 0, 0, 0);
      add(0, 0, 0, 32'h0,        0, 32'h0,        1,  1,   32'h0,        0, 0, 0, 0); // BOOT bubble
      add(0, 0, 0, 32'h0,        0, 32'h0,        1,  1,   32'h0,        1, 0, 0, 0);
      add(0, 0, 0, 32'h0,        0, 32'h0,        1,  1,   32'h4,        1, 0, 0, 1);
      add(0, 0, 0, 32'h0,        0, 32'h0,        1,  1,   32'h8,        1, 0, 0, 2);
      add(0, 0, 0, 32'h0,        0, 32'h0,        1,  1,   32'hC,        1, 0, 0, 3);
      add(0, 1, 0, 32'h0,        0, 32'h0,        1,  1,   32'h10,       1, 0, 0, 4); // stall -> HOLD
      add(0, 1, 0, 32'h0,        0, 32'h0,        1,  1,   32'h10,       0, 0, 0, 4);
      add(0, 1, 0, 32'h0,        0, 32'h0,        1,  1,   32'h10,       0, 0, 0, 4);
      add(0, 0, 0, 32'h0,        0, 32'h0,        1,  1,   32'h10,       0, 0, 0, 4);
      add(0, 0, 0, 32'h0,        0, 32'h0,        1,  1,   32'h10,       1, 0, 0, 4);
      add(0, 0, 1, 32'h200,      1, 32'h400,      1,  1,   32'h14,       1, 0, 0, 5); // jump beats branch
      add(0, 0, 0, 32'h0,        0, 32'h0,        1,  1,   32'h400,      1, 1, 0, 5);
      add(0, 0, 1, 32'h20,       0, 32'h0,        1,  1,   32'h404,      1, 0, 0, 6);
      add(0, 0, 0, 32'h0,        0, 32'h0,        0,  1,   32'h20,       1, 1, 0, 6); // back-pressure
      add(0, 0, 0, 32'h0,        0, 32'h0,        0,  1,   32'h20,       1, 0, 0, 6);
      add(0, 0, 0, 32'h0,        0, 32'h0,        1,  1,   32'h20,       1, 0, 0, 6);
      add(0, 0, 0, 32'h0,        1, 32'h80,       1,  1,   32'h24,       1, 0, 0, 7);
      add(0, 0, 1, 32'h90,       0, 32'h0,        1,  1,   32'h80,       1, 1, 0, 7); // back-to-back
      add(0, 1, 0, 32'h0,        0, 32'h0,        1,  1,   32'h90,       1, 1, 0, 7);
      add(0, 1, 0, 32'h0,        1, 32'hFFFFFFFC, 1,  1,   32'h90,       0, 0, 0, 7); // redirect from HOLD
      add(0, 0, 0, 32'h0,        0, 32'h0,        1,  1,   32'hFFFFFFFC, 1, 1, 0, 7);
      add(0, 0, 0, 32'h0,        0, 32'h0,        1,  1,   32'h0,        1, 0, 0, 8); // wrapped
      add(0, 0, 1, 32'h102,      0, 32'h0,        1,  1,   32'h4,        1, 0, 0, 9); // misaligned
      add(0, 0, 0, 32'h0,        1, 32'h40,       1,  1,   32'h4,        0, 0, 1, 9);
      add(0, 0, 0, 32'h0,        0, 32'h0,        1,  1,   32'h4,        0, 0, 1, 9);
      add(1, 1, 0, 32'h0,        0, 32'h0,        1,  1,   32'h4,        0, 0, 1, 9);
      add(0, 0, 0, 32'h0,        1, 32'h44,       1,  1,   32'h0,        0, 0, 0, 0); // BOOT ignores redirect
      add(0, 0, 1, 32'h200,      1, 32'h41,       1,  1,   32'h0,        1, 0, 0, 0); // misaligned jump wins
      add(0, 0, 0, 32'h0,        0, 32'h0,        1,  1,   32'h0,        0, 0, 1, 0);
      add(1, 0, 0, 32'h0,        0, 32'h0,        1,  1,   32'h0,        0, 0, 1, 0);
      add(0, 1, 0, 32'h0,        0, 32'h0,        1,  1,   32'h0,        0, 0, 0, 0);
      add(0, 1, 0, 32'h0,        0, 32'h0,        1,  1,   32'h0,        1, 0, 0, 0);
      add(0, 1, 1, 32'h3,        0, 32'h0,        1,  1,   32'h0,        0, 0, 0, 0); // misaligned from HOLD
      add(0, 0, 0, 32'h0,        0, 32'h0,        1,  1,   32'h0,        0, 0, 1, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rst, tbl[i].stall, tbl[i].br, tbl[i].bt, tbl[i].jmp, tbl[i].jt, tbl[i].rdy);
         @(negedge Clk);
         if (tbl[i].chk)
            check_all(i, tbl[i].pc, tbl[i].fv, tbl[i].fl, tbl[i].ae, tbl[i].cnt);
         @(posedge Clk); #1;
      end

      // ERROR is absorbing: nothing but Reset leaves it.
      for (int i = 0; i < 16; i++) begin
         drive(0, 1'($urandom), 1'($urandom), 32'h100, 1'($urandom), 32'h200, 1'($urandom));
         @(negedge Clk);
         check_all(100 + i, 32'h0, 0, 0, 1, 0);
         @(posedge Clk); #1;
      end

      // Sequential fetch under irregular back-pressure against a small model.
      drive(1, 0, 0, 0, 0, 0, 1);
      @(posedge Clk); #1;
      drive(0, 0, 0, 0, 0, 0, 1);
      @(posedge Clk); #1;
      m_pc  = 32'h0;
      m_cnt = 16'h0;
      for (int i = 0; i < 12; i++) begin
         r = (i % 3) != 0;
         drive(0, 0, 0, 0, 0, 0, r);
         @(negedge Clk);
         check_all(200 + i, m_pc, 1, 0, 0, m_cnt);
         @(posedge Clk); #1;
         if (r) begin
            m_pc  = m_pc + 32'd4;
            m_cnt = m_cnt + 16'd1;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
